// File: rtl/bomb_placer_if.sv
// Placement request bundle from bomb_placer to the bomb-map updater.
// master drives requests and readiness; slave consumes them.
interface bomb_placer_if;
    logic       bombA_v;
    logic [3:0] bombA_x;
    logic [3:0] bombA_y;
    logic       bombB_v;
    logic [3:0] bombB_x;
    logic [3:0] bombB_y;
    logic       readyA;
    logic       readyB;

    modport master (
        output bombA_v, bombA_x, bombA_y,
        output bombB_v, bombB_x, bombB_y,
        output readyA, readyB
    );

    modport slave (
        input bombA_v, bombA_x, bombA_y,
        input bombB_v, bombB_x, bombB_y,
        input readyA, readyB
    );
endinterface

// File: rtl/bomb_placer.sv
// Two-player bomb placement request generator: press detect, cooldown,
// one owned live bomb per player, border/occupancy filtering, A-wins arbitration.
module bomb_placer #(
    parameter int COOLDOWN = 3
) (
    input  logic          bombClk,
    input  logic          rst,
    input  logic          btnA,
    input  logic          btnB,
    input  logic [3:0]    playerAx,
    input  logic [3:0]    playerAy,
    input  logic [3:0]    playerBx,
    input  logic [3:0]    playerBy,
    input  logic [99:0]   i_curBombMap_0,
    input  logic [99:0]   i_curBombMap_1,
    input  logic [1:0]    game_state,
    bomb_placer_if.master bus
);

    function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return 8'(x) * 8'd10 + 8'(y);
    endfunction

    function automatic logic cell_occ(input logic [99:0] occ_map, input logic [7:0] idx);
        return (idx < 8'd100) ? occ_map[idx[6:0]] : 1'b0;
    endfunction

    function automatic logic in_field(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd8);
    endfunction

    // Index 0 is player A, index 1 is player B.
    logic [1:0]      v_q, v_d;
    logic [1:0][3:0] x_q, x_d;
    logic [1:0][3:0] y_q, y_d;
    logic [1:0][3:0] cd_q, cd_d;
    logic [1:0]      slot_v_q, slot_v_d;
    logic [1:0]      slot_armed_q, slot_armed_d;
    logic [1:0][6:0] slot_xy_q, slot_xy_d;
    logic [1:0]      ready_q, ready_d;
    logic [1:0]      btn_prev_q, btn_prev_d;

    logic [99:0]     occ_map;
    logic [1:0]      btn;
    logic [1:0][3:0] px, py;
    logic [1:0][7:0] tgt;
    logic [1:0]      cand, acc;

    always_comb begin
        occ_map = i_curBombMap_1 | i_curBombMap_0;
        btn     = {btnB, btnA};
        px      = {playerBx, playerAx};
        py      = {playerBy, playerAy};
        tgt     = '0;
        cand    = '0;

        for (int p = 0; p < 2; p++) begin
            tgt[p]  = cell_idx(px[p], py[p]);
            cand[p] = (game_state == 2'd0) && btn[p] && !btn_prev_q[p] &&
                      (cd_q[p] == 4'd0) && !slot_v_q[p] &&
                      in_field(px[p]) && in_field(py[p]) &&
                      !cell_occ(occ_map, tgt[p]);
        end

        // Same-cell collision: A takes the cell, B is dropped without side effects.
        acc[0] = cand[0];
        acc[1] = cand[1] && !(cand[0] && (tgt[0] == tgt[1]));

        v_d          = '0;
        x_d          = x_q;
        y_d          = y_q;
        cd_d         = cd_q;
        slot_v_d     = slot_v_q;
        slot_armed_d = slot_armed_q;
        slot_xy_d    = slot_xy_q;
        ready_d      = '0;
        btn_prev_d   = btn;

        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
                v_d[p]          = 1'b1;
                x_d[p]          = px[p];
                y_d[p]          = py[p];
                cd_d[p]         = 4'(COOLDOWN);
                slot_v_d[p]     = 1'b1;
                slot_armed_d[p] = 1'b0;
                slot_xy_d[p]    = tgt[p][6:0];
            end else begin
                if (cd_q[p] != 4'd0)
                    cd_d[p] = cd_q[p] - 4'd1;
                // The map lags the request by two edges, so arm only once the bomb shows up.
                if (slot_v_q[p] && !slot_armed_q[p] && cell_occ(occ_map, {1'b0, slot_xy_q[p]}))
                    slot_armed_d[p] = 1'b1;
                else if (slot_v_q[p] && slot_armed_q[p] && !cell_occ(occ_map, {1'b0, slot_xy_q[p]})) begin
                    slot_v_d[p]     = 1'b0;
                    slot_armed_d[p] = 1'b0;
                end
            end
            ready_d[p] = (cd_d[p] == 4'd0) && !slot_v_d[p];
        end
    end

    always_ff @(posedge bombClk) begin
        if (rst) begin
            v_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cd_q         <= '0;
            slot_v_q     <= '0;
            slot_armed_q <= '0;
            slot_xy_q    <= '0;
            ready_q      <= 2'b11;
            btn_prev_q   <= 2'b11;
        end else begin
            v_q          <= v_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cd_q         <= cd_d;
            slot_v_q     <= slot_v_d;
            slot_armed_q <= slot_armed_d;
            slot_xy_q    <= slot_xy_d;
            ready_q      <= ready_d;
            btn_prev_q   <= btn_prev_d;
        end
    end

    assign bus.bombA_v = v_q[0];
    assign bus.bombA_x = x_q[0];
    assign bus.bombA_y = y_q[0];
    assign bus.bombB_v = v_q[1];
    assign bus.bombB_x = x_q[1];
    assign bus.bombB_y = y_q[1];
    assign bus.readyA  = ready_q[0];
    assign bus.readyB  = ready_q[1];

endmodule

// File: tb/tb_bomb_placer.sv
// Directed bench for bomb_placer: reset state, placement, arbitration,
// border/occupancy filtering, slot release, cooldown and game-over gating.
module tb_bomb_placer;
    logic         bombClk = 1'b0;
    logic         rst;
    logic         btnA, btnB;
    logic [3:0]   playerAx, playerAy, playerBx, playerBy;
    logic [99:0]  map0, map1;
    logic [1:0]   game_state;

    int checks = 0;
    int errors = 0;

    bomb_placer_if bus ();

    bomb_placer #(.COOLDOWN(3)) dut (
        .bombClk        (bombClk),
        .rst            (rst),
        .btnA           (btnA),
        .btnB           (btnB),
        .playerAx       (playerAx),
        .playerAy       (playerAy),
        .playerBx       (playerBx),
        .playerBy       (playerBy),
        .i_curBombMap_0 (map0),
        .i_curBombMap_1 (map1),
        .game_state     (game_state),
        .bus            (bus.master)
    );

    always #5 bombClk = ~bombClk;

    task automatic step();
        @(posedge bombClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic hold_btn);
        rst = 1'b1; btnA = hold_btn; btnB = 1'b0;
        map0 = '0; map1 = '0; game_state = 2'd0;
        playerAx = 4'd0; playerAy = 4'd0; playerBx = 4'd0; playerBy = 4'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state and basic placement with cooldown count
        do_reset(1'b0);
        chk("rst_vA", 8'(bus.bombA_v), 8'd0);
        chk("rst_vB", 8'(bus.bombB_v), 8'd0);
        chk("rst_xA", 8'(bus.bombA_x), 8'd0);
        chk("rst_yA", 8'(bus.bombA_y), 8'd0);
        chk("rst_rdyA", 8'(bus.readyA), 8'd1);
        chk("rst_rdyB", 8'(bus.readyB), 8'd1);
        playerAx = 4'd3; playerAy = 4'd4;
        step();
        btnA = 1'b1;
        step();
        chk("t1_vA", 8'(bus.bombA_v), 8'd1);
        chk("t1_xA", 8'(bus.bombA_x), 8'd3);
        chk("t1_yA", 8'(bus.bombA_y), 8'd4);
        chk("t1_rdyA", 8'(bus.readyA), 8'd0);
        chk("t1_cd3", 8'(dut.cd_q[0]), 8'd3);
        btnA = 1'b0;
        step();
        chk("t1_pulse", 8'(bus.bombA_v), 8'd0);
        chk("t1_cd2", 8'(dut.cd_q[0]), 8'd2);
        step();
        chk("t1_cd1", 8'(dut.cd_q[0]), 8'd1);
        step();
        chk("t1_cd0", 8'(dut.cd_q[0]), 8'd0);
        chk("t1_hold_x", 8'(bus.bombA_x), 8'd3);
        chk("t1_slot_busy", 8'(bus.readyA), 8'd0);

        // Same-cell collision: A wins
        do_reset(1'b0);
        playerAx = 4'd5; playerAy = 4'd5; playerBx = 4'd5; playerBy = 4'd5;
        step();
        btnA = 1'b1; btnB = 1'b1;
        step();
        chk("t2_vA", 8'(bus.bombA_v), 8'd1);
        chk("t2_vB", 8'(bus.bombB_v), 8'd0);
        chk("t2_rdyB", 8'(bus.readyB), 8'd1);
        chk("t2_xA", 8'(bus.bombA_x), 8'd5);

        // Occupied cell, border cells, valid corner
        do_reset(1'b0);
        playerAx = 4'd4; playerAy = 4'd4;
        map0[44] = 1'b1;
        step();
        btnA = 1'b1;
        step();
        chk("t3_occ_vA", 8'(bus.bombA_v), 8'd0);
        chk("t3_occ_rdyA", 8'(bus.readyA), 8'd1);
        btnA = 1'b0; map0 = '0; playerAx = 4'd0;
        playerBx = 4'd9; playerBy = 4'd5;
        step();
        btnA = 1'b1; btnB = 1'b1;
        step();
        chk("t3_borderA", 8'(bus.bombA_v), 8'd0);
        chk("t3_borderB", 8'(bus.bombB_v), 8'd0);
        btnA = 1'b0; playerAx = 4'd8; playerAy = 4'd1;
        step();
        btnA = 1'b1;
        step();
        chk("t3_corner_v", 8'(bus.bombA_v), 8'd1);
        chk("t3_corner_x", 8'(bus.bombA_x), 8'd8);
        chk("t3_corner_y", 8'(bus.bombA_y), 8'd1);

        // Slot tracking: arm on occupancy, release on clear
        do_reset(1'b0);
        playerAx = 4'd2; playerAy = 4'd6;
        step();
        btnA = 1'b1;
        step();
        chk("t4_vA", 8'(bus.bombA_v), 8'd1);
        map0[26] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_occ_vA", 8'(bus.bombA_v), 8'd0);
            chk("t4_occ_rdy", 8'(bus.readyA), 8'd0);
        end
        map1[26] = 1'b1;
        step();
        chk("t4_both_vA", 8'(bus.bombA_v), 8'd0);
        chk("t4_both_rdy", 8'(bus.readyA), 8'd0);
        map0 = '0; map1 = '0;
        step();
        chk("t4_rel_rdy", 8'(bus.readyA), 8'd1);
        chk("t4_rel_vA", 8'(bus.bombA_v), 8'd0);
        btnA = 1'b0;
        step();
        btnA = 1'b1;
        step();
        chk("t4_again_vA", 8'(bus.bombA_v), 8'd1);

        // Cooldown still blocks after an early slot release
        do_reset(1'b0);
        playerAx = 4'd7; playerAy = 4'd7;
        step();
        btnA = 1'b1;
        step();
        chk("t5_vA", 8'(bus.bombA_v), 8'd1);
        map0[77] = 1'b1; btnA = 1'b0;
        step();
        map0 = '0;
        step();
        chk("t5_cd_rdy", 8'(bus.readyA), 8'd0);
        btnA = 1'b1;
        step();
        chk("t5_cd_block", 8'(bus.bombA_v), 8'd0);
        chk("t5_cd_done", 8'(bus.readyA), 8'd1);
        btnA = 1'b0;
        step();
        btnA = 1'b1;
        step();
        chk("t5_after_cd", 8'(bus.bombA_v), 8'd1);

        // Game over: no requests, cooldown keeps running
        do_reset(1'b0);
        playerAx = 4'd3; playerAy = 4'd3; playerBx = 4'd6; playerBy = 4'd6;
        step();
        btnA = 1'b1;
        step();
        chk("t6_vA", 8'(bus.bombA_v), 8'd1);
        game_state = 2'd2; btnA = 1'b0; btnB = 1'b1;
        step();
        chk("t6_go_vB", 8'(bus.bombB_v), 8'd0);
        chk("t6_go_rdyB", 8'(bus.readyB), 8'd1);
        chk("t6_go_cd2", 8'(dut.cd_q[0]), 8'd2);
        step();
        step();
        chk("t6_go_cd0", 8'(dut.cd_q[0]), 8'd0);
        chk("t6_go_vA", 8'(bus.bombA_v), 8'd0);

        // Button held through reset
        do_reset(1'b1);
        playerAx = 4'd3; playerAy = 4'd4;
        step();
        chk("t7_held_v1", 8'(bus.bombA_v), 8'd0);
        step();
        chk("t7_held_v2", 8'(bus.bombA_v), 8'd0);
        btnA = 1'b0;
        step();
        btnA = 1'b1;
        step();
        chk("t7_press_v", 8'(bus.bombA_v), 8'd1);

        // Reset on the accepting edge drops the request
        do_reset(1'b0);
        playerAx = 4'd3; playerAy = 4'd4;
        step();
        btnA = 1'b1; rst = 1'b1;
        step();
        chk("t8_rst_v", 8'(bus.bombA_v), 8'd0);
        chk("t8_rst_rdy", 8'(bus.readyA), 8'd1);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
